// File: rtl/noc_rx_port_pkg.sv
// Shared types and helpers for the NoC receive port.
package noc_rx_port_pkg;

  localparam int unsigned RxCountWidth = 32;

  typedef logic [RxCountWidth-1:0] rx_count_t;

  localparam rx_count_t RxCountMax = '1;

  // Decoded per-cycle buffer operation.
  typedef struct packed {
    logic flush;
    logic push;
    logic pop;
  } rx_op_t;

  // Saturating increment for the accepted-beat counter.
  function automatic rx_count_t sat_inc(rx_count_t v);
    return (v == RxCountMax) ? v : v + rx_count_t'(1);
  endfunction

endpackage

// File: rtl/noc_rx_port_if.sv
// Handshake bundle between a tile_noc master port, the receive buffer and tile logic.
interface noc_rx_port_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  // NoC side: beats offered into the port.
  logic                  in_wvalid;
  logic                  in_wready;
  logic [DATA_WIDTH-1:0] in_wdata;

  // Tile side: buffered beats leaving the port.
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Environment: offers beats and consumes the head.
  modport master (
    output in_wvalid,
    output in_wdata,
    output out_ready,
    input  in_wready,
    input  out_valid,
    input  out_data
  );

  // Receive port itself.
  modport slave (
    input  in_wvalid,
    input  in_wdata,
    input  out_ready,
    output in_wready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/noc_rx_port.sv
// Receive buffer for one tile_noc master port: first-word-fall-through FIFO with
// registered ready, synchronous flush and a saturating accepted-beat counter.
module noc_rx_port
  import noc_rx_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  noc_rx_port_if.slave             rx,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output rx_count_t                rx_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [OccW-1:0] occ_t;

  localparam occ_t OccFull = occ_t'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      rd_ptr_q, rd_ptr_d;
  occ_t      occ_q, occ_d;
  logic      wready_q, wready_d;
  rx_count_t rx_count_q, rx_count_d;
  rx_op_t    op;

  // Decode this cycle's operation; flush suppresses both push and pop.
  always_comb begin
    op       = '0;
    op.flush = flush;
    op.push  = rx.in_wvalid && wready_q && !flush;
    op.pop   = (occ_q != '0) && rx.out_ready && !flush;
  end

  // Next-state for pointers, occupancy, ready and counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    rx_count_d = rx_count_q;

    if (op.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (op.push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (op.pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      if (op.push && !op.pop) begin
        occ_d = occ_q + occ_t'(1);
      end else if (op.pop && !op.push) begin
        occ_d = occ_q - occ_t'(1);
      end
    end

    if (op.push) begin
      rx_count_d = sat_inc(rx_count_q);
    end

    // Ready looks ahead at next occupancy so a pop from full reopens next cycle.
    wready_d = (occ_d < OccFull) && !op.flush;
  end

  // Storage write: payload is only captured on an accepted beat.
  always_comb begin
    mem_d = mem_q;
    if (op.push) begin
      mem_d[wr_ptr_q] = rx.in_wdata;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      wready_q   <= 1'b0;
      rx_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      wready_q   <= wready_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Storage array; contents are irrelevant while occupancy is zero, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs come straight from registers: no same-cycle pass-through.
  always_comb begin
    rx.in_wready = wready_q;
    rx.out_valid = (occ_q != '0);
    rx.out_data  = mem_q[rd_ptr_q];
    occupancy    = occ_q;
    rx_count     = rx_count_q;
  end

endmodule

// File: tb/tb_noc_rx_port.sv
// Self-checking bench for noc_rx_port: queue-based reference model, per-cycle
// comparison, directed scenarios with literal expectations and a random phase.
module tb_noc_rx_port;
  import noc_rx_port_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic      clk;
  logic      rstn;
  logic      flush;
  logic [2:0] occupancy;
  rx_count_t rx_count;

  noc_rx_port_if #(.DATA_WIDTH(DW)) bus ();

  noc_rx_port #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (bus),
    .flush    (flush),
    .occupancy(occupancy),
    .rx_count (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;

  // Reference model state.
  logic [DW-1:0] m_q[$];
  logic          m_wready = 1'b0;
  logic [31:0]   m_rx     = '0;
  bit            m_acc    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO queue updated on each rising edge, cleared by async reset.
  initial begin
    bit do_push, do_pop;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_q.delete();
        m_wready = 1'b0;
        m_rx     = '0;
        m_acc    = 1'b0;
      end else begin
        do_push = bus.in_wvalid && m_wready && !flush;
        do_pop  = (m_q.size() != 0) && bus.out_ready && !flush;
        m_acc   = do_push;
        if (flush) m_q.delete();
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back(bus.in_wdata);
          if (m_rx != 32'hFFFF_FFFF) m_rx = m_rx + 1;
        end
        m_wready = (m_q.size() < DEPTH) && !flush;
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("in_wready", 32'(bus.in_wready), 32'(m_wready));
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk("occupancy", 32'(occupancy), 32'(m_q.size()));
        chk("rx_count", rx_count, m_rx);
        if (m_q.size() != 0) chk("out_data", bus.out_data, m_q[0]);
      end
    end
  end

  // One clock: drive inputs just after the falling edge, return just after the rising edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    @(negedge clk);
    #1;
    bus.in_wvalid = v;
    bus.in_wdata  = v ? d : 'x;
    bus.out_ready = r;
    flush         = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn          = 1'b0;
    bus.in_wvalid = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    run           = 1'b1;
    #1;
    chk("rst_in_wready", 32'(bus.in_wready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_rx_count", rx_count, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_wready", 32'(bus.in_wready), 32'd1);
    chk("rel_occupancy", 32'(occupancy), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int idx, g;
    bit r, f, v;
    rstn          = 1'b1;
    flush         = 1'b0;
    bus.in_wvalid = 1'b0;
    bus.in_wdata  = '0;
    bus.out_ready = 1'b0;

    // Reset and single beat of all ones.
    do_reset();
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    bus.in_wvalid = 1'b0;
    chk("single_out_valid", 32'(bus.out_valid), 32'd1);
    chk("single_out_data", bus.out_data, 32'hFFFF_FFFF);
    chk("single_occupancy", 32'(occupancy), 32'd1);
    chk("single_rx_count", rx_count, 32'd1);

    // Fill with 1..5 while the tile stalls; 5 must wait for a pop.
    do_reset();
    idx = 0;
    g   = 0;
    while (idx < 4 && g < 20) begin
      cyc(1'b1, DW'(idx + 1), 1'b0, 1'b0);
      if (m_acc) idx++;
      g++;
    end
    chk("fill_accepted", 32'(idx), 32'd4);
    repeat (3) begin
      cyc(1'b1, 32'd5, 1'b0, 1'b0);
      chk("fill_held", 32'(m_acc), 32'd0);
    end
    chk("full_in_wready", 32'(bus.in_wready), 32'd0);
    chk("full_occupancy", 32'(occupancy), 32'd4);
    cyc(1'b1, 32'd5, 1'b1, 1'b0);
    chk("pop_full_in_wready", 32'(bus.in_wready), 32'd1);
    cyc(1'b1, 32'd5, 1'b0, 1'b0);
    chk("fill_5_accepted", 32'(m_acc), 32'd1);
    chk("refill_occupancy", 32'(occupancy), 32'd4);
    got.delete();
    g = 0;
    while (got.size() < 4 && g < 20) begin
      if (bus.out_valid) got.push_back(bus.out_data);
      cyc(1'b0, '0, 1'b1, 1'b0);
      g++;
    end
    chk("drain_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) chk("drain_order", got[k], 32'(k + 2));
    end

    // Streaming 0..19 with both sides always ready.
    do_reset();
    got.delete();
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) got.push_back(bus.out_data);
      cyc(1'b1, DW'(i), 1'b1, 1'b0);
      chk("stream_occupancy", 32'(occupancy), 32'd1);
    end
    chk("stream_rx_count", rx_count, 32'd20);
    g = 0;
    while (got.size() < 20 && g < 10) begin
      if (bus.out_valid) got.push_back(bus.out_data);
      cyc(1'b0, '0, 1'b1, 1'b0);
      g++;
    end
    chk("stream_count", 32'(got.size()), 32'd20);
    for (int k = 0; k < 20; k++) begin
      if (k < got.size()) chk("stream_order", got[k], 32'(k));
    end

    // Flush with three beats buffered and a beat offered the same cycle.
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'hAA, 1'b0, 1'b1);
    chk("flush_acc", 32'(m_acc), 32'd0);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_rx_count", rx_count, 32'd3);
    chk("flush_in_wready", 32'(bus.in_wready), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_in_wready", 32'(bus.in_wready), 32'd1);

    // Asynchronous reset between edges with two beats buffered.
    do_reset();
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    bus.in_wvalid = 1'b0;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    do_reset();
    repeat (3) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic with varying back-pressure, flushes and occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 60 : 95);
      for (int c = 0; c < 60; c++) begin
        v = ($urandom_range(0, 99) < 70);
        r = ($urandom_range(0, 99) < rdy_pct);
        f = ($urandom_range(0, 99) < 4);
        cyc(v, DW'($urandom), r, f);
      end
      if (blk == 4) do_reset();
    end

    bus.in_wvalid = 1'b0;
    flush         = 1'b0;
    repeat (2) @(posedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
